// File: rtl/lsu_agu.sv
// rtl/lsu_agu.sv - load/store address generation and dcache sequencing ahead of writeback
// Optional alignment fault reporting is enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_agu (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_uop,
  input  logic [31:0] in_base,
  input  logic [31:0] in_offset,
  input  logic        in_up,
  input  logic        in_pre,
  input  logic        in_wback,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rn,
  input  logic [31:0] in_store_data,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_data_in,
  output logic [4:0]  cache_uop,
  input  logic [31:0] cache_data_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_rd_en,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_rd_data,
  output logic        wb_rn_en,
  output logic [3:0]  wb_rn,
  output logic [31:0] wb_rn_data,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam logic [4:0] STR_UOP = 5'b01001;
  localparam logic [4:0] LDR_UOP = 5'b01010;
  localparam logic [4:0] NOP_UOP = 5'b00000;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_READ, S_WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] cache_addr_q, cache_addr_d;
  logic [31:0] cache_data_in_q, cache_data_in_d;
  logic [4:0]  cache_uop_q, cache_uop_d;
  logic [3:0]  rd_q, rd_d, rn_q, rn_d;
  logic [31:0] upd_q, upd_d;
  logic        wback_q, wback_d;
  logic        is_ld_q, is_ld_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_rd_en_q, wb_rd_en_d;
  logic        wb_rn_en_q, wb_rn_en_d;
  logic [31:0] wb_rd_data_q, wb_rd_data_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic [31:0] upd, ea;
  logic        is_mem, misaligned;

  assign upd    = in_up ? (in_base + in_offset) : (in_base - in_offset);
  assign ea     = in_pre ? upd : in_base;
  assign is_mem = (in_uop == STR_UOP) || (in_uop == LDR_UOP);

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = |ea[1:0];
`else
  // Byte offset within the word is dropped when alignment checking is off.
  logic unused_ea_lsb;
  assign unused_ea_lsb = ^ea[1:0];
  assign misaligned    = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    cache_addr_d    = cache_addr_q;
    cache_data_in_d = cache_data_in_q;
    cache_uop_d     = cache_uop_q;
    rd_d            = rd_q;
    rn_d            = rn_q;
    upd_d           = upd_q;
    wback_d         = wback_q;
    is_ld_d         = is_ld_q;
    wb_valid_d      = wb_valid_q;
    wb_rd_en_d      = wb_rd_en_q;
    wb_rn_en_d      = wb_rn_en_q;
    wb_rd_data_d    = wb_rd_data_q;
    fault_d         = 1'b0;
    fault_addr_d    = fault_addr_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && is_mem) begin
          if (misaligned) begin
            fault_d      = 1'b1;
            fault_addr_d = ea;
          end else begin
            cache_addr_d    = {2'b00, ea[31:2]};
            cache_uop_d     = in_uop;
            cache_data_in_d = (in_uop == STR_UOP) ? in_store_data : 32'h0;
            rd_d            = in_rd;
            rn_d            = in_rn;
            upd_d           = upd;
            wback_d         = in_wback;
            is_ld_d         = (in_uop == LDR_UOP);
            state_d         = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // dcache samples the op on this edge, so the request is withdrawn here.
        cache_uop_d     = NOP_UOP;
        cache_data_in_d = 32'h0;
        if (is_ld_q) begin
          state_d = S_READ;
        end else if (wback_q) begin
          wb_valid_d = 1'b1;
          wb_rd_en_d = 1'b0;
          wb_rn_en_d = 1'b1;
          state_d    = S_WB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        wb_rd_data_d = cache_data_out;
        wb_rd_en_d   = 1'b1;
        wb_rn_en_d   = wback_q;
        wb_valid_d   = 1'b1;
        state_d      = S_WB;
      end
      S_WB: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          wb_rd_en_d = 1'b0;
          wb_rn_en_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cache_addr_q    <= 32'h0;
      cache_data_in_q <= 32'h0;
      cache_uop_q     <= NOP_UOP;
      rd_q            <= 4'h0;
      rn_q            <= 4'h0;
      upd_q           <= 32'h0;
      wback_q         <= 1'b0;
      is_ld_q         <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_rd_en_q      <= 1'b0;
      wb_rn_en_q      <= 1'b0;
      wb_rd_data_q    <= 32'h0;
      fault_q         <= 1'b0;
      fault_addr_q    <= 32'h0;
    end else begin
      state_q         <= state_d;
      cache_addr_q    <= cache_addr_d;
      cache_data_in_q <= cache_data_in_d;
      cache_uop_q     <= cache_uop_d;
      rd_q            <= rd_d;
      rn_q            <= rn_d;
      upd_q           <= upd_d;
      wback_q         <= wback_d;
      is_ld_q         <= is_ld_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_en_q      <= wb_rd_en_d;
      wb_rn_en_q      <= wb_rn_en_d;
      wb_rd_data_q    <= wb_rd_data_d;
      fault_q         <= fault_d;
      fault_addr_q    <= fault_addr_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign cache_addr    = cache_addr_q;
  assign cache_data_in = cache_data_in_q;
  assign cache_uop     = cache_uop_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd_en      = wb_rd_en_q;
  assign wb_rd         = rd_q;
  assign wb_rd_data    = wb_rd_data_q;
  assign wb_rn_en      = wb_rn_en_q;
  assign wb_rn         = rn_q;
  assign wb_rn_data    = upd_q;
  assign fault         = fault_q;
  assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_lsu_agu.sv
// tb/tb_lsu_agu.sv - scoreboard bench for lsu_agu with a behavioural dcache attached
module tb_lsu_agu;

  localparam logic [4:0] STR_UOP = 5'b01001;
  localparam logic [4:0] LDR_UOP = 5'b01010;
  localparam logic [4:0] NOP_UOP = 5'b00000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_uop;
  logic [31:0] in_base, in_offset;
  logic        in_up, in_pre, in_wback;
  logic [3:0]  in_rd, in_rn;
  logic [31:0] in_store_data;
  logic [31:0] cache_addr, cache_data_in;
  logic [4:0]  cache_uop;
  logic [31:0] cache_data_out = 32'h0;
  logic        wb_valid, wb_ready;
  logic        wb_rd_en, wb_rn_en;
  logic [3:0]  wb_rd, wb_rn;
  logic [31:0] wb_rd_data, wb_rn_data;
  logic        fault;
  logic [31:0] fault_addr;

  lsu_agu dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
    .in_base(in_base), .in_offset(in_offset), .in_up(in_up), .in_pre(in_pre),
    .in_wback(in_wback), .in_rd(in_rd), .in_rn(in_rn), .in_store_data(in_store_data),
    .cache_addr(cache_addr), .cache_data_in(cache_data_in), .cache_uop(cache_uop),
    .cache_data_out(cache_data_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd_en(wb_rd_en), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
    .wb_rn_en(wb_rn_en), .wb_rn(wb_rn), .wb_rn_data(wb_rn_data),
    .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural dcache: samples registered uop, read data valid the following cycle.
  logic [31:0] dmem [logic [31:0]];
  always @(posedge clock) begin
    if (cache_uop == STR_UOP) dmem[cache_addr] = cache_data_in;
    else if (cache_uop == LDR_UOP) cache_data_out <= dmem.exists(cache_addr) ? dmem[cache_addr] : 32'h0;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  uop;
    logic [31:0] data;
  } cache_exp_t;

  typedef struct packed {
    logic        rd_en;
    logic [3:0]  rd;
    logic [31:0] rd_data;
    logic        rn_en;
    logic [3:0]  rn;
    logic [31:0] rn_data;
  } wb_exp_t;

  cache_exp_t  cache_q[$];
  wb_exp_t     wb_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  cache_exp_t  ce;
  wb_exp_t     we;

  int errors = 0;
  int checks = 0;
  int last_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (cache_uop != NOP_UOP) begin
        if (cache_q.size() == 0) begin
          check("unexpected_cache_uop", {27'h0, cache_uop}, 32'h0);
        end else begin
          ce = cache_q.pop_front();
          check("cache_addr", cache_addr, ce.addr);
          check("cache_uop", {27'h0, cache_uop}, {27'h0, ce.uop});
          check("cache_data_in", cache_data_in, ce.data);
        end
      end
      if (wb_valid && wb_ready) begin
        if (wb_q.size() == 0) begin
          check("unexpected_wb", {31'h0, wb_valid}, 32'h0);
        end else begin
          we = wb_q.pop_front();
          check("wb_rd_en", {31'h0, wb_rd_en}, {31'h0, we.rd_en});
          check("wb_rd", {28'h0, wb_rd}, {28'h0, we.rd});
          if (we.rd_en) check("wb_rd_data", wb_rd_data, we.rd_data);
          check("wb_rn_en", {31'h0, wb_rn_en}, {31'h0, we.rn_en});
          check("wb_rn", {28'h0, wb_rn}, {28'h0, we.rn});
          check("wb_rn_data", wb_rn_data, we.rn_data);
        end
      end
    end
  end

  // Drives one op, pushes its expected dcache access and writeback, returns just after the accepting edge.
  task automatic issue(input logic [4:0] uop, input logic [31:0] base, input logic [31:0] off,
                       input logic up, input logic pre, input logic wbk,
                       input logic [3:0] rd, input logic [3:0] rn,
                       input logic [31:0] sd, input logic drop_wb);
    logic [31:0] upd, ea, word;
    logic        mis, mem_op;
    int          n;
    upd    = up ? base + off : base - off;
    ea     = pre ? upd : base;
    word   = ea >> 2;
    mem_op = (uop == STR_UOP) || (uop == LDR_UOP);
`ifdef LSU_ALIGN_CHECK_EN
    mis = |ea[1:0];
`else
    mis = 1'b0;
`endif
    in_uop = uop; in_base = base; in_offset = off; in_up = up; in_pre = pre;
    in_wback = wbk; in_rd = rd; in_rn = rn; in_store_data = sd; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {31'h0, in_ready}, 32'h1);
    if (mem_op && !mis) begin
      cache_q.push_back('{addr: word, uop: uop, data: (uop == STR_UOP) ? sd : 32'h0});
      if ((uop == LDR_UOP || wbk) && !drop_wb)
        wb_q.push_back('{rd_en: (uop == LDR_UOP), rd: rd,
                         rd_data: ref_mem.exists(word) ? ref_mem[word] : 32'h0,
                         rn_en: wbk, rn: rn, rn_data: upd});
      if (uop == STR_UOP) ref_mem[word] = sd;
    end
    @(posedge clock); #1;
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(in_ready && !wb_valid) && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (!(in_ready && !wb_valid)) check("drain_timeout", {31'h0, in_ready}, 32'h1);
  endtask

  int t0;

  initial begin
    reset_n = 1'b0; wb_ready = 1'b1; in_valid = 1'b0; in_uop = 5'h0; in_base = 32'h0;
    in_offset = 32'h0; in_up = 1'b0; in_pre = 1'b0; in_wback = 1'b0; in_rd = 4'h0;
    in_rn = 4'h0; in_store_data = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_cache_uop", {27'h0, cache_uop}, 32'h0);
    check("rst_cache_addr", cache_addr, 32'h0);
    check("rst_cache_data_in", cache_data_in, 32'h0);
    check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    check("rst_wb_en", {30'h0, wb_rd_en, wb_rn_en}, 32'h0);
    check("rst_wb_regs", {24'h0, wb_rd, wb_rn}, 32'h0);
    check("rst_wb_rd_data", wb_rd_data, 32'h0);
    check("rst_wb_rn_data", wb_rn_data, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // STR, pre-indexed, no writeback
    issue(STR_UOP, 32'h28, 32'h0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h12345678, 1'b0);
    check("str_access_uop", {27'h0, cache_uop}, {27'h0, STR_UOP});
    check("str_access_busy", {31'h0, in_ready}, 32'h0);
    @(posedge clock); #1;
    check("str_ready_t1", {31'h0, in_ready}, 32'h1);
    check("str_uop_nop_t1", {27'h0, cache_uop}, 32'h0);
    check("str_no_wb", {31'h0, wb_valid}, 32'h0);

    // LDR back from the same word
    issue(LDR_UOP, 32'h28, 32'h0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h1, 32'h0, 1'b0);
    check("ldr_wb_t0", {31'h0, wb_valid}, 32'h0);
    @(posedge clock); #1;
    check("ldr_wb_t1", {31'h0, wb_valid}, 32'h0);
    @(posedge clock); #1;
    check("ldr_wb_t2", {31'h0, wb_valid}, 32'h1);
    check("ldr_wb_rd_data", wb_rd_data, 32'h12345678);
    check("ldr_wb_rn_en", {31'h0, wb_rn_en}, 32'h0);
    drain();

    // STR post-indexed with writeback, then stalled post-indexed LDR
    issue(STR_UOP, 32'h14, 32'h8, 1'b1, 1'b0, 1'b1, 4'h0, 4'h2, 32'hCAFEF00D, 1'b0);
    @(posedge clock); #1;
    check("strwb_valid_t1", {31'h0, wb_valid}, 32'h1);
    check("strwb_rd_en", {31'h0, wb_rd_en}, 32'h0);
    drain();
    wb_ready = 1'b0;
    issue(LDR_UOP, 32'h14, 32'h4, 1'b0, 1'b0, 1'b1, 4'h7, 4'h5, 32'h0, 1'b0);
    check("post_ldr_addr", cache_addr, 32'h5);
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_wb_valid", {31'h0, wb_valid}, 32'h1);
      check("stall_in_ready", {31'h0, in_ready}, 32'h0);
      check("stall_rd_data", wb_rd_data, 32'hCAFEF00D);
      check("stall_rn_data", wb_rn_data, 32'h10);
      check("stall_en", {30'h0, wb_rd_en, wb_rn_en}, 32'h3);
      check("stall_regs", {24'h0, wb_rd, wb_rn}, 32'h75);
      @(posedge clock); #1;
    end
    wb_ready = 1'b1;
    @(posedge clock); #1;
    check("stall_release_valid", {31'h0, wb_valid}, 32'h0);
    check("stall_release_ready", {31'h0, in_ready}, 32'h1);

    // Non-memory uop is swallowed
    issue(5'b00010, 32'h40, 32'h0, 1'b1, 1'b1, 1'b1, 4'h1, 4'h1, 32'h0, 1'b0);
    check("nonmem_ready", {31'h0, in_ready}, 32'h1);
    check("nonmem_uop", {27'h0, cache_uop}, 32'h0);
    @(posedge clock); #1;
    check("nonmem_no_wb", {31'h0, wb_valid}, 32'h0);

    // Reset while the LDR is in READ
    issue(LDR_UOP, 32'h28, 32'h0, 1'b1, 1'b1, 1'b1, 4'h2, 4'h4, 32'h0, 1'b1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rstmid_wb_valid", {31'h0, wb_valid}, 32'h0);
      check("rstmid_in_ready", {31'h0, in_ready}, 32'h1);
      @(posedge clock); #1;
    end

    // Misaligned effective address
    issue(LDR_UOP, 32'h22, 32'h0, 1'b1, 1'b1, 1'b0, 4'h4, 4'h0, 32'h0, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_fault", {31'h0, fault}, 32'h1);
    check("mis_fault_addr", fault_addr, 32'h22);
    check("mis_uop", {27'h0, cache_uop}, 32'h0);
    check("mis_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clock); #1;
    check("mis_fault_pulse", {31'h0, fault}, 32'h0);
`else
    check("mis_addr", cache_addr, 32'h8);
    check("mis_fault", {31'h0, fault}, 32'h0);
    check("mis_fault_addr", fault_addr, 32'h0);
    drain();
`endif

    // Throughput with wb_ready high
    issue(STR_UOP, 32'h100, 32'h0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
    t0 = last_acc;
    issue(STR_UOP, 32'h104, 32'h0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h5A5A5A5A, 1'b0);
    check("str_throughput", last_acc - t0, 32'd2);
    issue(LDR_UOP, 32'h100, 32'h0, 1'b1, 1'b1, 1'b0, 4'h8, 4'h0, 32'h0, 1'b0);
    t0 = last_acc;
    issue(LDR_UOP, 32'h104, 32'h0, 1'b1, 1'b1, 1'b0, 4'h9, 4'h0, 32'h0, 1'b0);
    check("ldr_throughput", last_acc - t0, 32'd4);
    drain();

    // LDR with rd == rn and writeback asserts both enables
    issue(LDR_UOP, 32'hFC, 32'h4, 1'b1, 1'b1, 1'b1, 4'h6, 4'h6, 32'h0, 1'b0);
    drain();

    for (int i = 0; i < 12; i++) begin
      issue(($urandom_range(0, 1) == 1) ? STR_UOP : LDR_UOP,
            32'($urandom_range(0, 63)) << 2, 32'($urandom_range(0, 15)) << 2,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, 1'b0);
    end
    drain();
    repeat (2) @(posedge clock);
    #1;
    check("cache_q_empty", cache_q.size(), 32'd0);
    check("wb_q_empty", wb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
